// File: rtl/cfu_acc_requant_if.sv
// Handshake and configuration bundle between the MAC stage and the accumulate/requantize block.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry the valid-ready stall in each direction.
interface cfu_acc_requant_if #(
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [31:0]      in_sum;
  logic                    in_first;
  logic                    in_last;
  logic signed [31:0]      bias;
  logic signed [31:0]      multiplier;
  logic        [4:0]       shift;
  logic signed [31:0]      out_offset;
  logic signed [OUT_W-1:0] act_min;
  logic signed [OUT_W-1:0] act_max;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  // Producer/consumer side: drives beats and configuration, takes results.
  modport master (
    output in_valid, in_sum, in_first, in_last, bias, multiplier, shift,
           out_offset, act_min, act_max, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Block side.
  modport slave (
    input  in_valid, in_sum, in_first, in_last, bias, multiplier, shift,
           out_offset, act_min, act_max, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cfu_acc_requant.sv
// Accumulates MAC partial sums, adds bias, requantizes (SRDHM + rounding shift), offsets and clamps.
// Latency: result registered 3 cycles after the accepted in_last beat (S1, S2, output register).
// Backpressure: global stall; in_ready drops and every stage holds while a result waits on out_ready.
module cfu_acc_requant #(
  parameter int OUT_W = 8
) (
  input logic             clk,
  input logic             reset_n,
  cfu_acc_requant_if.slave io
);
  logic                    stall;
  logic                    accept;
  logic signed [31:0]      acc;
  logic signed [31:0]      acc_next;

  logic                    s1_valid;
  logic signed [31:0]      s1_x;
  logic signed [31:0]      s1_mul;
  logic        [4:0]       s1_shift;
  logic signed [31:0]      s1_off;
  logic signed [OUT_W-1:0] s1_min;
  logic signed [OUT_W-1:0] s1_max;

  logic                    s2_valid;
  logic signed [31:0]      s2_y;
  logic        [4:0]       s2_shift;
  logic signed [31:0]      s2_off;
  logic signed [OUT_W-1:0] s2_min;
  logic signed [OUT_W-1:0] s2_max;

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;

  logic signed [63:0]      prod;
  logic signed [63:0]      prod_nudged;
  logic signed [63:0]      prod_rtz;
  logic signed [63:0]      prod_q;
  logic signed [31:0]      srdhm_y;

  logic        [31:0]      mask;
  logic        [31:0]      rem;
  logic        [31:0]      thr;
  logic signed [31:0]      rdbp_z;
  logic signed [32:0]      w;
  logic signed [32:0]      lo;
  logic signed [32:0]      hi;
  logic signed [32:0]      clamp_lo;
  logic signed [32:0]      clamp_res;

  assign stall       = out_valid_q && !io.out_ready;
  assign io.in_ready = !stall;
  assign accept      = io.in_valid && !stall;
  assign acc_next    = io.in_first ? io.in_sum : acc + io.in_sum;

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

  // Running sum; a beat without in_first simply adds onto whatever is held (0 after reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc_next;
    end
  end

  // S1: capture biased sum and the requant parameters on the closing beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_mul   <= '0;
      s1_shift <= '0;
      s1_off   <= '0;
      s1_min   <= '0;
      s1_max   <= '0;
    end else if (!stall) begin
      s1_valid <= accept && io.in_last;
      if (accept && io.in_last) begin
        s1_x     <= acc_next + io.bias;
        s1_mul   <= io.multiplier;
        s1_shift <= io.shift;
        s1_off   <= io.out_offset;
        s1_min   <= io.act_min;
        s1_max   <= io.act_max;
      end
    end
  end

  // Saturating rounding doubling high multiply; division by 2^31 truncates toward zero.
  always_comb begin
    prod        = s1_x * s1_mul;
    prod_nudged = prod + ((prod >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824));
    prod_rtz    = prod_nudged + ((prod_nudged < 0) ? 64'sd2147483647 : 64'sd0);
    prod_q      = prod_rtz >>> 31;
    if (s1_x == 32'sh8000_0000 && s1_mul == 32'sh8000_0000) begin
      srdhm_y = 32'sh7FFF_FFFF;
    end else begin
      srdhm_y = prod_q[31:0];
    end
  end

  // S2: register the SRDHM result with the downstream parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_shift <= '0;
      s2_off   <= '0;
      s2_min   <= '0;
      s2_max   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= srdhm_y;
        s2_shift <= s1_shift;
        s2_off   <= s1_off;
        s2_min   <= s1_min;
        s2_max   <= s1_max;
      end
    end
  end

  // Rounding divide by power of two, then offset and clamp; the upper bound wins when min > max.
  always_comb begin
    mask      = (32'd1 << s2_shift) - 32'd1;
    rem       = s2_y & mask;
    thr       = (mask >> 1) + {31'd0, s2_y[31]};
    rdbp_z    = (s2_y >>> s2_shift) + ((rem > thr) ? 32'sd1 : 32'sd0);
    w         = $signed({rdbp_z[31], rdbp_z}) + $signed({s2_off[31], s2_off});
    lo        = $signed({{(33-OUT_W){s2_min[OUT_W-1]}}, s2_min});
    hi        = $signed({{(33-OUT_W){s2_max[OUT_W-1]}}, s2_max});
    clamp_lo  = (w < lo) ? lo : w;
    clamp_res = (clamp_lo > hi) ? hi : clamp_lo;
  end

  // Output register; holds while the consumer stalls, clears on handshake when no new result arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_data_q <= clamp_res[OUT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_cfu_acc_requant.sv
// Directed bench for cfu_acc_requant: stimulus pushes hand-computed results into a queue,
// a negedge monitor pops and compares on every output handshake.
// Covers reset state, latency, rounding, saturation, clamping, wrap, backpressure and mid-run reset.
`timescale 1ns/1ps
module tb_cfu_acc_requant;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  cfu_acc_requant_if #(.OUT_W(OUT_W)) io ();

  cfu_acc_requant #(.OUT_W(OUT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: a handshake happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got %0d, expected no result", io.out_data);
      end else begin
        check("out_data", io.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cfg(input logic signed [31:0] b, input logic signed [31:0] m, input logic [4:0] sh,
                     input logic signed [31:0] off, input logic signed [7:0] lo, input logic signed [7:0] hi);
    io.bias       = b;
    io.multiplier = m;
    io.shift      = sh;
    io.out_offset = off;
    io.act_min    = lo;
    io.act_max    = hi;
  endtask

  // Present one beat and return at posedge+1 once it has been accepted.
  task automatic send(input logic signed [31:0] sum, input bit first, input bit last, input int expv);
    int n;
    n = 0;
    io.in_sum   = sum;
    io.in_first = first;
    io.in_last  = last;
    io.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (io.in_ready !== 1'b1 && n < 100);
    if (io.in_ready !== 1'b1) check("in_ready_timeout", io.in_ready, 1);
    @(posedge clk);
    #1;
    if (last) exp_q.push_back(expv);
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    io.in_valid  = 1'b0;
    io.in_sum    = '0;
    io.in_first  = 1'b0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b1;
    cfg(0, 32'sh4000_0000, 0, 0, -128, 127);
    #1;
    check("reset_out_valid", io.out_valid, 0);
    check("reset_out_data", io.out_data, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_in_ready", io.in_ready, 1);

    // Beat without in_first right after reset adds onto 0: 20 -> 10.
    send(20, 0, 1, 10);
    drain();

    // Single beat, latency of 3 cycles: 100 * 0.5 -> 50.
    send(100, 1, 1, 50);
    @(negedge clk); check("lat_c1_valid", io.out_valid, 0);
    @(negedge clk); check("lat_c2_valid", io.out_valid, 0);
    @(negedge clk); check("lat_c3_valid", io.out_valid, 1);
    drain();

    // Four beats sum 100, bias -4 -> 96, ~x1.0, >>2 -> 24, offset -128 -> -104.
    cfg(-4, 32'sh7FFF_FFFF, 2, -128, -128, 127);
    send(10, 1, 0, 0);
    send(20, 0, 0, 0);
    send(30, 0, 0, 0);
    send(40, 0, 1, -104);

    // Negative rounding: -6 -> SRDHM -3 -> RDBP(1) -2.
    cfg(0, 32'sh4000_0000, 1, 0, -128, 127);
    send(-6, 1, 1, -2);

    // Saturated SRDHM then shift 31 -> 1.
    cfg(0, 32'sh8000_0000, 31, 0, -128, 127);
    send(32'sh8000_0000, 1, 1, 1);

    // Upper and lower clamp.
    cfg(0, 32'sh4000_0000, 0, 0, -128, 127);
    send(1000, 1, 1, 127);
    send(-1000, 1, 1, -128);

    // Positive offset on a negative value: -20 -> -10 + 5 -> -5.
    cfg(0, 32'sh4000_0000, 0, 5, -128, 127);
    send(-20, 1, 1, -5);

    // act_min > act_max resolves to act_max.
    cfg(0, 32'sh4000_0000, 0, 0, 10, -10);
    send(4, 1, 1, -10);

    // Accumulator wraps: 0x7FFFFFFF + 1 = -2^31 -> -2^30 -> clamp -128.
    cfg(0, 32'sh4000_0000, 0, 0, -128, 127);
    send(32'sh7FFF_FFFF, 1, 0, 0);
    send(1, 0, 1, -128);
    drain();

    // Back-to-back results at one per cycle.
    send(2, 1, 1, 1);
    send(4, 1, 1, 2);
    send(6, 1, 1, 3);
    send(-8, 1, 1, -4);
    drain();

    // Backpressure: three results fill out/S2/S1, then the block must stall.
    io.out_ready = 1'b0;
    send(100, 1, 1, 50);
    send(60, 1, 1, 30);
    send(40, 1, 1, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", io.out_valid, 1);
      check("stall_in_ready", io.in_ready, 0);
      check("stall_out_data", io.out_data, 50);
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    send(-10, 1, 1, -5);
    drain();

    // Mid-run reset with a result at the output, one in S2 and an accumulation open.
    send(40, 1, 1, 20);
    send(60, 1, 1, 30);
    send(100, 1, 0, 0);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", io.out_valid, 0);
    check("midreset_out_data", io.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    check("inreset_out_valid", io.out_valid, 0);
    reset_n = 1'b1;
    check("postreset_in_ready", io.in_ready, 1);
    // Accumulator must restart from 0: 8 -> 4.
    send(8, 0, 1, 4);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
